fpu_issue_ctrl: RTL and testbench

//  Sequencer that sits directly upstream of the combinational FPU datapath and owns the FP register file.

---
 rtl/fpu_issue_ctrl_if.sv | 45 ++++
 rtl/fpu_issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl_if
// Bundles the decode request channel and the FPU operand/result bus that
// fpu_issue_ctrl sits between.
//
// Request handshake: an instruction transfers on every rising edge where
// req_valid and req_ready are both high. The requester holds req_valid and
// the req_op/req_fs/req_ft/req_fd fields stable until that edge. req_ready
// depends only on controller state, never on req_valid.
//
// Signals
//   req_valid  requester -> ctrl   instruction present
//   req_ready  ctrl -> requester   controller can accept this cycle
//   req_op     requester -> ctrl   0 ADD,1 SUB,2 EQ,3 LT,4 GT,5 LE,6 GE,7 MOV
//   req_fs/ft  requester -> ctrl   source register addresses
//   req_fd     requester -> ctrl   destination register address
//   fpu_a/b    ctrl -> FPU         registered operands
//   fpu_op     ctrl -> FPU         registered opcode
//   fpu_result FPU -> ctrl         combinational FPU result, bit0 = compare flag
// Modports: master = decode + FPU side, slave = the controller.
// ---------------------------------------------------------------------------
interface fpu_issue_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [REG_AW-1:0] req_fs;
  logic [REG_AW-1:0] req_ft;
  logic [REG_AW-1:0] req_fd;
  logic [31:0]       fpu_a;
  logic [31:0]       fpu_b;
  logic [2:0]        fpu_op;
  logic [31:0]       fpu_result;

  modport master (
    output req_valid, req_op, req_fs, req_ft, req_fd, fpu_result,
    input  req_ready, fpu_a, fpu_b, fpu_op
  );

  modport slave (
    input  req_valid, req_op, req_fs, req_ft, req_fd, fpu_result,
    output req_ready, fpu_a, fpu_b, fpu_op
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl
// Issue sequencer in front of a combinational FPU. Owns the FP register file.
// One instruction at a time: IDLE accepts and latches operands, EXEC holds
// fpu_a/b/op for FPU_LATENCY cycles and samples fpu_result on the last one,
// WB writes rf[fd] (arith/MOV) or cc_flag (compares) and pulses done.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          fpu_issue_ctrl_if.slave: request handshake + FPU bus
//   ext_we/ext_waddr/ext_wdata  external register write, honoured in any state
//   dbg_raddr/dbg_rdata         combinational register read
//   cc_flag      condition code from the last compare
//   busy         high whenever not IDLE
//   done         one-cycle pulse in the WB cycle
//   dbg_state    current FSM state (0 IDLE, 1 EXEC, 2 WB)
// ---------------------------------------------------------------------------
module fpu_issue_ctrl #(
  parameter int FPU_LATENCY = 1,
  parameter int NREGS       = 32,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  fpu_issue_ctrl_if.slave   bus,
  input  logic              ext_we,
  input  logic [REG_AW-1:0] ext_waddr,
  input  logic [31:0]       ext_wdata,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [31:0]       dbg_rdata,
  output logic              cc_flag,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // Counter reload: EXEC lasts FPU_LATENCY cycles, sampling when cnt hits 0.
  localparam logic [3:0] CNT_INIT = 4'(FPU_LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept, capture, wb_rf, wb_cc;

  logic [31:0]       rf_q [NREGS];
  logic [31:0]       fpu_a_q, fpu_b_q, res_q;
  logic [2:0]        fpu_op_q;
  logic [REG_AW-1:0] fd_q;
  logic              is_cmp_q;
  logic              cc_q;

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    wb_rf   = 1'b0;
    wb_cc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        if (is_cmp_q) wb_cc = 1'b1;
        else          wb_rf = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand/opcode latch, result capture and condition code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_a_q  <= 32'd0;
      fpu_b_q  <= 32'd0;
      fpu_op_q <= 3'd0;
      fd_q     <= '0;
      is_cmp_q <= 1'b0;
      res_q    <= 32'd0;
      cc_q     <= 1'b0;
    end else begin
      if (accept) begin
        // Reads the register file as it stood before this edge, so a
        // same-edge external write to fs/ft is not forwarded.
        fpu_a_q  <= rf_q[bus.req_fs];
        fpu_b_q  <= rf_q[bus.req_ft];
        fpu_op_q <= bus.req_op;
        fd_q     <= bus.req_fd;
        is_cmp_q <= (bus.req_op >= 3'd2) && (bus.req_op <= 3'd6);
      end
      if (capture) res_q <= bus.fpu_result;
      if (wb_cc)   cc_q  <= res_q[0];
    end
  end

  // Register file. The writeback assignment comes last so that it wins over
  // an external write to the same address on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) rf_q[r] <= 32'd0;
    end else begin
      if (ext_we) rf_q[ext_waddr] <= ext_wdata;
      if (wb_rf)  rf_q[fd_q]      <= res_q;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.fpu_a     = fpu_a_q;
  assign bus.fpu_b     = fpu_b_q;
  assign bus.fpu_op    = fpu_op_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_WB);
  assign cc_flag       = cc_q;
  assign dbg_rdata     = rf_q[dbg_raddr];
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpu_issue_ctrl
// Two controllers: u0 with FPU_LATENCY=1, u1 with FPU_LATENCY=4. Each has a
// small FPU model on its bus. A cycle-timed reference model tracks register
// contents, condition code and the accept time of the in-flight instruction;
// a compare process checks all outputs every cycle, and directed scenarios
// add literal expectations.
// ---------------------------------------------------------------------------
module tb_fpu_issue_ctrl;

  localparam int L0 = 1;
  localparam int L1 = 4;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_LT = 3'd3,
                         OP_GE = 3'd6, OP_MOV = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  fpu_issue_ctrl_if #(.REG_AW(5)) if0 ();
  fpu_issue_ctrl_if #(.REG_AW(5)) if1 ();

  logic        ext_we    [2];
  logic [4:0]  ext_waddr [2];
  logic [31:0] ext_wdata [2];
  logic [4:0]  dbg_raddr [2];
  logic [31:0] dbg_rdata [2];
  logic        cc_flag   [2];
  logic        busy      [2];
  logic        done      [2];
  logic [1:0]  dbg_state [2];
  logic        garble    [2];
  logic        garble_en [2];
  logic        chk_en = 1'b0;

  fpu_issue_ctrl #(.FPU_LATENCY(L0), .NREGS(32), .REG_AW(5)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave),
    .ext_we(ext_we[0]), .ext_waddr(ext_waddr[0]), .ext_wdata(ext_wdata[0]),
    .dbg_raddr(dbg_raddr[0]), .dbg_rdata(dbg_rdata[0]), .cc_flag(cc_flag[0]),
    .busy(busy[0]), .done(done[0]), .dbg_state(dbg_state[0])
  );

  fpu_issue_ctrl #(.FPU_LATENCY(L1), .NREGS(32), .REG_AW(5)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave),
    .ext_we(ext_we[1]), .ext_waddr(ext_waddr[1]), .ext_wdata(ext_wdata[1]),
    .dbg_raddr(dbg_raddr[1]), .dbg_rdata(dbg_rdata[1]), .cc_flag(cc_flag[1]),
    .busy(busy[1]), .done(done[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- FPU model (single precision via double) ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    real ra, rb;
    ra = f2r(a);
    rb = f2r(b);
    case (op)
      3'd0: return r2f(ra + rb);
      3'd1: return r2f(ra - rb);
      3'd2: return {31'd0, ra == rb};
      3'd3: return {31'd0, ra <  rb};
      3'd4: return {31'd0, ra >  rb};
      3'd5: return {31'd0, ra <= rb};
      3'd6: return {31'd0, ra >= rb};
      default: return a;
    endcase
  endfunction

  // garble flips the result on every EXEC cycle except the one that is sampled
  assign if0.fpu_result = fpu_fn(if0.fpu_a, if0.fpu_b, if0.fpu_op) ^ (garble[0] ? 32'hFFFF_FFFF : 32'h0);
  assign if1.fpu_result = fpu_fn(if1.fpu_a, if1.fpu_b, if1.fpu_op) ^ (garble[1] ? 32'hFFFF_FFFF : 32'h0);

  function automatic int lat(input int i);
    return (i == 0) ? L0 : L1;
  endfunction

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // An instruction accepted at edge A samples fpu_result at edge A+L, writes
  // back at edge A+L+1; busy spans edges A..A+L, done follows edge A+L.
  int          cyc = 0;
  logic [31:0] m_rf  [2][32];
  logic        m_inf [2];
  int          m_acc [2];
  logic [31:0] m_a [2], m_b [2], m_res [2];
  logic [2:0]  m_op [2];
  logic [4:0]  m_fd [2];
  logic        m_cmp [2];
  logic        m_cc [2];
  logic        s_vld, acc_now, wb_now;
  logic [2:0]  s_op;
  logic [4:0]  s_fs, s_ft, s_fd;
  logic [31:0] s_fres;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_inf[i] = 1'b0; m_acc[i] = 0; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0;
        m_op[i] = '0; m_fd[i] = '0; m_cmp[i] = 1'b0; m_cc[i] = 1'b0;
        for (int r = 0; r < 32; r++) m_rf[i][r] = '0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        s_vld  = (i == 0) ? if0.req_valid  : if1.req_valid;
        s_op   = (i == 0) ? if0.req_op     : if1.req_op;
        s_fs   = (i == 0) ? if0.req_fs     : if1.req_fs;
        s_ft   = (i == 0) ? if0.req_ft     : if1.req_ft;
        s_fd   = (i == 0) ? if0.req_fd     : if1.req_fd;
        s_fres = (i == 0) ? if0.fpu_result : if1.fpu_result;
        acc_now = !m_inf[i] && s_vld;
        wb_now  = m_inf[i] && (cyc == m_acc[i] + lat(i) + 1);
        if (m_inf[i] && (cyc == m_acc[i] + lat(i))) m_res[i] = s_fres;
        if (acc_now) begin
          m_a[i]   = m_rf[i][s_fs];
          m_b[i]   = m_rf[i][s_ft];
          m_op[i]  = s_op;
          m_fd[i]  = s_fd;
          m_cmp[i] = (s_op >= 3'd2) && (s_op <= 3'd6);
          m_acc[i] = cyc;
        end
        if (ext_we[i]) m_rf[i][ext_waddr[i]] = ext_wdata[i];
        if (wb_now) begin
          if (m_cmp[i]) m_cc[i] = m_res[i][0];
          else          m_rf[i][m_fd[i]] = m_res[i];
        end
        if (acc_now)     m_inf[i] = 1'b1;
        else if (wb_now) m_inf[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      garble[i] = garble_en[i] && m_inf[i] && (cyc - m_acc[i] < lat(i) - 1);
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(posedge clk);
    #2;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d_ready", i), (i == 0) ? if0.req_ready : if1.req_ready, !m_inf[i]);
        check($sformatf("u%0d_busy", i), busy[i], m_inf[i]);
        check($sformatf("u%0d_done", i), done[i], m_inf[i] && (cyc == m_acc[i] + lat(i)));
        check($sformatf("u%0d_fpu_a", i), (i == 0) ? if0.fpu_a : if1.fpu_a, m_a[i]);
        check($sformatf("u%0d_fpu_b", i), (i == 0) ? if0.fpu_b : if1.fpu_b, m_b[i]);
        check($sformatf("u%0d_fpu_op", i), (i == 0) ? if0.fpu_op : if1.fpu_op, m_op[i]);
        check($sformatf("u%0d_cc", i), cc_flag[i], m_cc[i]);
        check($sformatf("u%0d_dbg", i), dbg_rdata[i], m_rf[i][dbg_raddr[i]]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [4:0] fs, input logic [4:0] ft, input logic [4:0] fd);
    if (i == 0) begin
      if0.req_valid = v; if0.req_op = op; if0.req_fs = fs; if0.req_ft = ft; if0.req_fd = fd;
    end else begin
      if1.req_valid = v; if1.req_op = op; if1.req_fs = fs; if1.req_ft = ft; if1.req_fd = fd;
    end
  endtask

  // Returns #1 after the accept edge; acc is that edge's number.
  task automatic issue(input int i, input logic [2:0] op, input logic [4:0] fs,
                       input logic [4:0] ft, input logic [4:0] fd, output int acc);
    int w;
    @(negedge clk);
    set_req(i, 1'b1, op, fs, ft, fd);
    w = 0;
    while (!((i == 0) ? if0.req_ready : if1.req_ready) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("issue_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    acc = cyc;
    set_req(i, 1'b0, op, fs, ft, fd);
  endtask

  task automatic ext_write(input int i, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    ext_we[i] = 1'b1; ext_waddr[i] = a; ext_wdata[i] = d;
    @(negedge clk);
    ext_we[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int w;
    w = 0;
    @(posedge clk);
    #1;
    while (busy[i] && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 40) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic peek(input int i, input logic [4:0] r, input logic [31:0] exp, input string name);
    @(negedge clk);
    dbg_raddr[i] = r;
    #1;
    check(name, dbg_rdata[i], exp);
    check({name, "_model"}, m_rf[i][r], exp);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int acc, k;
    int acc_t [3];
    int n_acc;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
      ext_we[i] = 1'b0; ext_waddr[i] = '0; ext_wdata[i] = '0;
      dbg_raddr[i] = '0; garble_en[i] = 1'b0;
    end

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    check("rst_ready", if0.req_ready, 1'b1);
    check("rst_cc", cc_flag[0], 1'b0);
    check("rst_fpu_a", if0.fpu_a, 32'd0);
    check("rst_fpu_op", if1.fpu_op, 3'd0);
    check("rst_dbg", dbg_rdata[1], 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // ADD 1.0 + 2.0 into rf[3]
    ext_write(0, 5'd1, 32'h3F80_0000);
    ext_write(0, 5'd2, 32'h4000_0000);
    issue(0, OP_ADD, 5'd1, 5'd2, 5'd3, acc);
    check("add_fpu_a", if0.fpu_a, 32'h3F80_0000);
    check("add_fpu_b", if0.fpu_b, 32'h4000_0000);
    check("add_fpu_op", if0.fpu_op, 3'd0);
    k = 0;
    while (!done[0] && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("add_done_latency", k + 1, 2);
    wait_idle(0);
    peek(0, 5'd3, 32'h4040_0000, "add_rf3");

    // compares
    issue(0, OP_LT, 5'd1, 5'd2, 5'd9, acc);
    wait_idle(0);
    check("lt_cc", cc_flag[0], 1'b1);
    peek(0, 5'd9, 32'd0, "lt_rf9_untouched");
    issue(0, OP_GE, 5'd1, 5'd2, 5'd3, acc);
    wait_idle(0);
    check("ge_cc", cc_flag[0], 1'b0);
    peek(0, 5'd3, 32'h4040_0000, "ge_rf3_untouched");

    // MOV and ready-low window
    issue(0, OP_MOV, 5'd2, 5'd0, 5'd5, acc);
    k = 0;
    while (!if0.req_ready && k < 20) begin
      k++;
      @(posedge clk);
      #1;
    end
    check("mov_ready_low_cycles", k, L0 + 1);
    peek(0, 5'd5, 32'h4000_0000, "mov_rf5");
    ext_write(0, 5'd0, 32'hC000_0000);
    peek(0, 5'd0, 32'hC000_0000, "rf0_writable");

    // writeback collides with ext write to the same register
    issue(0, OP_SUB, 5'd1, 5'd2, 5'd3, acc);
    @(negedge clk);
    @(negedge clk);
    check("coll_in_wb", done[0], 1'b1);
    ext_we[0] = 1'b1; ext_waddr[0] = 5'd3; ext_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    ext_we[0] = 1'b0;
    peek(0, 5'd3, 32'hBF80_0000, "coll_same_rf3");

    // ext write to a different register in WB: both land
    issue(0, OP_ADD, 5'd1, 5'd2, 5'd3, acc);
    @(negedge clk);
    @(negedge clk);
    ext_we[0] = 1'b1; ext_waddr[0] = 5'd4; ext_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    ext_we[0] = 1'b0;
    peek(0, 5'd3, 32'h4040_0000, "coll_diff_rf3");
    peek(0, 5'd4, 32'hDEAD_BEEF, "coll_diff_rf4");

    // latency 4, request held: accepts spaced L+2, only last EXEC cycle sampled
    ext_write(1, 5'd1, 32'h3F80_0000);
    ext_write(1, 5'd2, 32'h4000_0000);
    garble_en[1] = 1'b1;
    @(negedge clk);
    set_req(1, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd6);
    n_acc = 0;
    for (int c = 0; c < 40 && n_acc < 3; c++) begin
      if (if1.req_ready) begin
        acc_t[n_acc] = cyc + 1;
        n_acc++;
      end
      if (n_acc < 3) @(negedge clk);
    end
    check("b2b_accept_count", n_acc, 3);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, OP_ADD, 5'd1, 5'd2, 5'd6);
    check("b2b_gap1", acc_t[1] - acc_t[0], L1 + 2);
    check("b2b_gap2", acc_t[2] - acc_t[1], L1 + 2);
    wait_idle(1);
    garble_en[1] = 1'b0;
    peek(1, 5'd6, 32'h4040_0000, "b2b_rf6");

    // ext write during EXEC does not disturb the in-flight op
    issue(1, OP_ADD, 5'd1, 5'd2, 5'd7, acc);
    ext_write(1, 5'd1, 32'h4080_0000);
    wait_idle(1);
    peek(1, 5'd7, 32'h4040_0000, "exec_ext_rf7");
    peek(1, 5'd1, 32'h4080_0000, "exec_ext_rf1");

    // reset in the middle of EXEC
    issue(0, OP_LT, 5'd1, 5'd2, 5'd0, acc);
    wait_idle(0);
    check("pre_rst_cc", cc_flag[0], 1'b1);
    issue(1, OP_ADD, 5'd1, 5'd2, 5'd8, acc);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy[1], 1'b0);
    check("midrst_ready", if1.req_ready, 1'b1);
    check("midrst_done", done[1], 1'b0);
    check("midrst_cc", cc_flag[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      dbg_raddr[0] = 5'(r);
      dbg_raddr[1] = 5'(r);
      #1;
      check($sformatf("midrst_u0_rf%0d", r), dbg_rdata[0], 32'd0);
      check($sformatf("midrst_u1_rf%0d", r), dbg_rdata[1], 32'd0);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midrst_no_done", done[1], 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
